// File: rtl/vga_timing_gen.sv
// Dual-mode VGA raster timing generator with pixel clock-enable, programmable
// sync polarity, data enable, line/frame start pulses and frame-boundary mode
// switching.
// Optional build macro: VTG_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned A_H_ACT  = 1024,
    parameter int unsigned A_H_FP   = 24,
    parameter int unsigned A_H_SYNC = 136,
    parameter int unsigned A_H_BP   = 160,
    parameter int unsigned A_V_ACT  = 768,
    parameter int unsigned A_V_FP   = 3,
    parameter int unsigned A_V_SYNC = 6,
    parameter int unsigned A_V_BP   = 29,
    parameter int unsigned B_H_ACT  = 800,
    parameter int unsigned B_H_FP   = 40,
    parameter int unsigned B_H_SYNC = 128,
    parameter int unsigned B_H_BP   = 88,
    parameter int unsigned B_V_ACT  = 600,
    parameter int unsigned B_V_FP   = 1,
    parameter int unsigned B_V_SYNC = 4,
    parameter int unsigned B_V_BP   = 23,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             pce,
    input  logic             mode_sel,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
`ifdef VTG_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             mode_cur
);

    typedef enum logic {MODE_A = 1'b0, MODE_B = 1'b1} mode_e;

    localparam int unsigned A_H_TOT = A_H_ACT + A_H_FP + A_H_SYNC + A_H_BP;
    localparam int unsigned A_V_TOT = A_V_ACT + A_V_FP + A_V_SYNC + A_V_BP;
    localparam int unsigned B_H_TOT = B_H_ACT + B_H_FP + B_H_SYNC + B_H_BP;
    localparam int unsigned B_V_TOT = B_V_ACT + B_V_FP + B_V_SYNC + B_V_BP;

    localparam logic [CNT_W-1:0] A_H_LAST = CNT_W'(A_H_TOT - 1);
    localparam logic [CNT_W-1:0] A_V_LAST = CNT_W'(A_V_TOT - 1);
    localparam logic [CNT_W-1:0] B_H_LAST = CNT_W'(B_H_TOT - 1);
    localparam logic [CNT_W-1:0] B_V_LAST = CNT_W'(B_V_TOT - 1);

    localparam logic [CNT_W-1:0] A_H_ACT_C = CNT_W'(A_H_ACT);
    localparam logic [CNT_W-1:0] A_HS_BEG  = CNT_W'(A_H_ACT + A_H_FP);
    localparam logic [CNT_W-1:0] A_HS_END  = CNT_W'(A_H_ACT + A_H_FP + A_H_SYNC);
    localparam logic [CNT_W-1:0] A_V_ACT_C = CNT_W'(A_V_ACT);
    localparam logic [CNT_W-1:0] A_VS_BEG  = CNT_W'(A_V_ACT + A_V_FP);
    localparam logic [CNT_W-1:0] A_VS_END  = CNT_W'(A_V_ACT + A_V_FP + A_V_SYNC);
    localparam logic [CNT_W-1:0] B_H_ACT_C = CNT_W'(B_H_ACT);
    localparam logic [CNT_W-1:0] B_HS_BEG  = CNT_W'(B_H_ACT + B_H_FP);
    localparam logic [CNT_W-1:0] B_HS_END  = CNT_W'(B_H_ACT + B_H_FP + B_H_SYNC);
    localparam logic [CNT_W-1:0] B_V_ACT_C = CNT_W'(B_V_ACT);
    localparam logic [CNT_W-1:0] B_VS_BEG  = CNT_W'(B_V_ACT + B_V_FP);
    localparam logic [CNT_W-1:0] B_VS_END  = CNT_W'(B_V_ACT + B_V_FP + B_V_SYNC);

    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             de_q, de_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    logic [CNT_W-1:0] h_last, v_last;
    logic [CNT_W-1:0] h_act_n, hs_beg_n, hs_end_n;
    logic [CNT_W-1:0] v_act_n, vs_beg_n, vs_end_n;

    // Wrap limits come from the mode in effect for the current frame.
    always_comb begin
        h_last = A_H_LAST;
        v_last = A_V_LAST;
        if (mode_q == MODE_B) begin
            h_last = B_H_LAST;
            v_last = B_V_LAST;
        end
    end

    // Raster counter and mode next-state; mode_sel only takes effect at the (0,0) wrap.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        mode_d = mode_q;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (pce) begin
            if (hcnt_q == h_last) begin
                hcnt_d = '0;
                ls_d   = 1'b1;
                if (vcnt_q == v_last) begin
                    vcnt_d = '0;
                    fs_d   = 1'b1;
                    mode_d = mode_e'(mode_sel);
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end
    end

    // Decode windows use the next mode so the first pixel of a switched frame is already decoded in the new timing.
    always_comb begin
        h_act_n  = A_H_ACT_C;
        hs_beg_n = A_HS_BEG;
        hs_end_n = A_HS_END;
        v_act_n  = A_V_ACT_C;
        vs_beg_n = A_VS_BEG;
        vs_end_n = A_VS_END;
        if (mode_d == MODE_B) begin
            h_act_n  = B_H_ACT_C;
            hs_beg_n = B_HS_BEG;
            hs_end_n = B_HS_END;
            v_act_n  = B_V_ACT_C;
            vs_beg_n = B_VS_BEG;
            vs_end_n = B_VS_END;
        end
    end

    // Sync/blank/de decode of the next pixel so every registered output describes the same position.
    always_comb begin
        hblnk_d = (hcnt_d >= h_act_n);
        vblnk_d = (vcnt_d >= v_act_n);
        de_d    = ~hblnk_d & ~vblnk_d;
        hsync_d = ((hcnt_d >= hs_beg_n) && (hcnt_d < hs_end_n)) ? HS_POL : ~HS_POL;
        vsync_d = ((vcnt_d >= vs_beg_n) && (vcnt_d < vs_end_n)) ? VS_POL : ~VS_POL;
    end

    // State and output registers; reset restarts at (0,0) and adopts mode_sel immediately.
    always_ff @(posedge pclk) begin
        if (rst) begin
            mode_q  <= mode_e'(mode_sel);
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
            de_q    <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            hblnk_q <= hblnk_d;
            vblnk_q <= vblnk_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VTG_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (fs_d) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign hcount      = hcnt_q;
    assign vcount      = vcnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign mode_cur    = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: dut0 uses the default 1024x768/800x600
// timings, dut1 uses tiny timings with active-low syncs so whole frames and
// mode switches fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hs, vs, hb, vb, de, ls, fs, mc;
    } obs_t;

    typedef struct {
        obs_t        o;
        int unsigned fc;
    } exp_t;

    typedef struct {
        int unsigned hact, hfp, hsy, hbp, vact, vfp, vsy, vbp;
    } tim_t;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic pce = 1'b0;
    logic mode_sel = 1'b0;

    logic [10:0] hc0, vc0, hc1, vc1;
    logic hs0, vs0, hb0, vb0, de0, ls0, fs0, mc0;
    logic hs1, vs1, hb1, vb1, de1, ls1, fs1, mc1;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    always #5 pclk = ~pclk;

    vga_timing_gen dut0 (
        .pclk(pclk), .rst(rst), .pce(pce), .mode_sel(mode_sel),
        .hcount(hc0), .vcount(vc0), .hsync(hs0), .vsync(vs0),
        .hblnk(hb0), .vblnk(vb0), .de(de0),
        .line_start(ls0), .frame_start(fs0),
`ifdef VTG_FRAME_CNT_EN
        .frame_cnt(fc0),
`endif
        .mode_cur(mc0)
    );

    vga_timing_gen #(
        .CNT_W(11),
        .A_H_ACT(16), .A_H_FP(2), .A_H_SYNC(3), .A_H_BP(4),
        .A_V_ACT(10), .A_V_FP(1), .A_V_SYNC(2), .A_V_BP(3),
        .B_H_ACT(12), .B_H_FP(1), .B_H_SYNC(2), .B_H_BP(3),
        .B_V_ACT(8),  .B_V_FP(1), .B_V_SYNC(1), .B_V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut1 (
        .pclk(pclk), .rst(rst), .pce(pce), .mode_sel(mode_sel),
        .hcount(hc1), .vcount(vc1), .hsync(hs1), .vsync(vs1),
        .hblnk(hb1), .vblnk(vb1), .de(de1),
        .line_start(ls1), .frame_start(fs1),
`ifdef VTG_FRAME_CNT_EN
        .frame_cnt(fc1),
`endif
        .mode_cur(mc1)
    );

    // Reference model state, one slot per DUT.
    tim_t        tim[2][2];
    bit          hpol[2], vpol[2];
    int unsigned mh[2], mv[2], mfc[2];
    bit          mm[2];

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit meas = 1'b0;

    // Hand-checked observation sets.
    bit hs0_seen[2048];
    bit hb0_seen[2048];
    bit de0_off[2048];
    bit vsA_seen[16];
    bit vsB_seen[16];
    int ls0_last = -1;
    int ls1_last = -1;
    bit ls1_mode = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_step(input int d, input bit r, input bit p, input bit s, output exp_t e);
        tim_t t;
        bit   l = 1'b0;
        bit   f = 1'b0;
        bit   hs_on, vs_on;
        if (r) begin
            mh[d]  = 0;
            mv[d]  = 0;
            mm[d]  = s;
            mfc[d] = 0;
        end else if (p) begin
            t = tim[d][mm[d]];
            if (mh[d] == t.hact + t.hfp + t.hsy + t.hbp - 1) begin
                mh[d] = 0;
                l = 1'b1;
                if (mv[d] == t.vact + t.vfp + t.vsy + t.vbp - 1) begin
                    mv[d]  = 0;
                    f      = 1'b1;
                    mm[d]  = s;
                    mfc[d] = (mfc[d] + 1) % 65536;
                end else begin
                    mv[d] = mv[d] + 1;
                end
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
        t = tim[d][mm[d]];
        hs_on = (mh[d] >= t.hact + t.hfp) && (mh[d] < t.hact + t.hfp + t.hsy);
        vs_on = (mv[d] >= t.vact + t.vfp) && (mv[d] < t.vact + t.vfp + t.vsy);
        e.o.h  = 11'(mh[d]);
        e.o.v  = 11'(mv[d]);
        e.o.hs = hs_on ? hpol[d] : ~hpol[d];
        e.o.vs = vs_on ? vpol[d] : ~vpol[d];
        e.o.hb = (mh[d] >= t.hact);
        e.o.vb = (mv[d] >= t.vact);
        e.o.de = !(e.o.hb || e.o.vb);
        e.o.ls = l;
        e.o.fs = f;
        e.o.mc = mm[d];
        e.fc   = mfc[d];
    endtask

    task automatic drive(input bit r, input bit p, input bit s);
        exp_t e;
        @(negedge pclk);
        rst = r;
        pce = p;
        mode_sel = s;
        model_step(0, r, p, s, e);
        q0.push_back(e);
        model_step(1, r, p, s, e);
        q1.push_back(e);
    endtask

    // Monitor: one registered output set per pclk, compared against the queued expectation.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge pclk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {hc0, vc0, hs0, vs0, hb0, vb0, de0, ls0, fs0, mc0};
                n_cmp++;
                if (a !== e.o) begin
                    n_err++;
                    $display("FAIL dut0_px cyc=%0d got h=%0d v=%0d hs,vs,hb,vb,de,ls,fs,mc=%b want h=%0d v=%0d hs,vs,hb,vb,de,ls,fs,mc=%b",
                             cyc, a.h, a.v, a[7:0], e.o.h, e.o.v, e.o[7:0]);
                end
`ifdef VTG_FRAME_CNT_EN
                chk("dut0_frame_cnt", int'(fc0), int'(e.fc));
`endif
                if (a.v == 11'd0 && !a.mc) begin
                    if (a.hs === 1'b1) hs0_seen[a.h] = 1'b1;
                    if (a.hb === 1'b1) hb0_seen[a.h] = 1'b1;
                    if (a.de === 1'b0) de0_off[a.h] = 1'b1;
                end
                if (meas && a.ls === 1'b1) begin
                    if (ls0_last >= 0) chk("dut0_line_period", cyc - ls0_last, 1344);
                    ls0_last = cyc;
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {hc1, vc1, hs1, vs1, hb1, vb1, de1, ls1, fs1, mc1};
                n_cmp++;
                if (a !== e.o) begin
                    n_err++;
                    $display("FAIL dut1_px cyc=%0d got h=%0d v=%0d hs,vs,hb,vb,de,ls,fs,mc=%b want h=%0d v=%0d hs,vs,hb,vb,de,ls,fs,mc=%b",
                             cyc, a.h, a.v, a[7:0], e.o.h, e.o.v, e.o[7:0]);
                end
`ifdef VTG_FRAME_CNT_EN
                chk("dut1_frame_cnt", int'(fc1), int'(e.fc));
`endif
                if (a.vs === 1'b0 && a.v < 11'd16) begin
                    if (a.mc) vsB_seen[a.v[3:0]] = 1'b1;
                    else      vsA_seen[a.v[3:0]] = 1'b1;
                end
                if (meas && a.ls === 1'b1) begin
                    if (ls1_last >= 0) chk("dut1_line_period", cyc - ls1_last, ls1_mode ? 18 : 25);
                    ls1_last = cyc;
                    ls1_mode = a.mc;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int cnt, lo, hi;
        tim[0][0] = '{1024, 24, 136, 160, 768, 3, 6, 29};
        tim[0][1] = '{800, 40, 128, 88, 600, 1, 4, 23};
        tim[1][0] = '{16, 2, 3, 4, 10, 1, 2, 3};
        tim[1][1] = '{12, 1, 2, 3, 8, 1, 1, 2};
        hpol[0] = 1'b1; vpol[0] = 1'b1;
        hpol[1] = 1'b0; vpol[1] = 1'b0;

        // Reset with pce high: reset must win.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);

        // Free run in mode A, then request B mid-frame (dut1 at vcount 8).
        meas = 1'b1;
        for (int i = 0; i < 1400; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1400; i++) drive(1'b0, 1'b1, 1'b1);
        meas = 1'b0;

`ifdef VTG_FRAME_CNT_EN
        @(posedge pclk);
        #2;
        force dut1.frame_cnt_q = 16'hFFFF;
        release dut1.frame_cnt_q;
        mfc[1] = 16'hFFFF;
`endif

        // Clock-enable pattern 1,0,0,1.
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
            drive(1'b0, 1'b1, 1'b1);
        end

        // Random clock-enable, mode request returning to A half-way.
        for (int i = 0; i < 600; i++) drive(1'b0, 1'($urandom_range(0, 1)), (i < 300));

        // Mid-frame reset back into mode A.
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge pclk);
        #2;
        chk("queue_drain", q0.size() + q1.size(), 0);

        // Mode A line 0 of dut0: hsync 1048..1183, blanking 1024..1343.
        cnt = 0; lo = 9999; hi = -1;
        for (int i = 0; i < 2048; i++) if (hs0_seen[i]) begin cnt++; if (i < lo) lo = i; hi = i; end
        chk("dut0_hsync_count", cnt, 136);
        chk("dut0_hsync_first", lo, 1048);
        chk("dut0_hsync_last", hi, 1183);
        cnt = 0; lo = 9999; hi = -1;
        for (int i = 0; i < 2048; i++) if (hb0_seen[i]) begin cnt++; if (i < lo) lo = i; hi = i; end
        chk("dut0_hblnk_count", cnt, 320);
        chk("dut0_hblnk_first", lo, 1024);
        chk("dut0_hblnk_last", hi, 1343);
        cnt = 0;
        for (int i = 0; i < 2048; i++) if (de0_off[i]) cnt++;
        chk("dut0_de_off_count", cnt, 320);

        // dut1 active-low vsync lines: A -> 11,12 ; B -> 9.
        cnt = 0;
        for (int i = 0; i < 16; i++) if (vsA_seen[i]) cnt++;
        chk("dut1_vsync_A_lines", cnt, 2);
        chk("dut1_vsync_A_l11", int'(vsA_seen[11]), 1);
        chk("dut1_vsync_A_l12", int'(vsA_seen[12]), 1);
        cnt = 0;
        for (int i = 0; i < 16; i++) if (vsB_seen[i]) cnt++;
        chk("dut1_vsync_B_lines", cnt, 1);
        chk("dut1_vsync_B_l9", int'(vsB_seen[9]), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
